tia_biphase_decoder: RTL and testbench

TIA_BIPHASE_DECODER -- requirements
Module: tia_biphase_decoder

---
 rtl/tia_biphase_decoder.sv | 151 +++++++++++++++
 tb/tb_tia_biphase_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tia_biphase_decoder.sv
// Two-phase (phi1/phi2) clock protocol checker: strobes legal phase edges, counts cycles, tracks lock.
// Optional stall watchdog enabled by defining TIA_BIPHASE_DECODER_WATCHDOG_EN.
`timescale 1ns/1ps
module tia_biphase_decoder #(
  parameter int STALL_MAX   = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rn,
  input  logic       phi1,
  input  logic       phi2,
  input  logic       clr,
  output logic       p1_rise,
  output logic       p2_rise,
  output logic [7:0] cycle_count,
  output logic       locked,
  output logic       err_overlap,
  output logic       err_order,
  output logic       err_stall
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {HUNT, P1, GAP1, P2, GAP2} state_t;

  state_t state, base_next, state_next;
  logic phi1_q, phi2_q;
  logic rise1, fall1, rise2, fall2, overlap;
  logic order_err, set_p1, set_p2;
  logic [LW-1:0] lock_cnt, lock_next;
  logic [7:0] count_next;
  logic locked_next, overlap_next, order_next;

  if (STALL_MAX < 1 || LOCK_CYCLES < 1) begin : g_param_check
    $error("tia_biphase_decoder: STALL_MAX and LOCK_CYCLES must be >= 1");
  end

  assign rise1   = phi1 & ~phi1_q;
  assign fall1   = ~phi1 & phi1_q;
  assign rise2   = phi2 & ~phi2_q;
  assign fall2   = ~phi2 & phi2_q;
  assign overlap = phi1 & phi2;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) state <= HUNT;
    else     state <= state_next;
  end

  // Overlap beats every per-state transition; order errors are wrong-phase rises inside a gap.
  always_comb begin
    base_next = state;
    order_err = 1'b0;
    set_p1    = 1'b0;
    set_p2    = 1'b0;
    if (overlap) begin
      base_next = HUNT;
    end else begin
      case (state)
        HUNT: if (rise1) begin base_next = P1; set_p1 = 1'b1; end
        P1:   if (fall1) base_next = GAP1;
        GAP1: begin
          if (rise1) begin
            base_next = HUNT;
            order_err = 1'b1;
          end else if (rise2) begin
            base_next = P2;
            set_p2    = 1'b1;
          end
        end
        P2:   if (fall2) base_next = GAP2;
        GAP2: begin
          if (rise2) begin
            base_next = HUNT;
            order_err = 1'b1;
          end else if (rise1) begin
            base_next = P1;
            set_p1    = 1'b1;
          end
        end
        default: base_next = HUNT;
      endcase
    end
  end

`ifdef TIA_BIPHASE_DECODER_WATCHDOG_EN
  localparam int SW = $clog2(STALL_MAX + 1);
  logic [SW-1:0] stall_cnt, stall_cnt_next;
  logic stall_err, stall_flag_next;

  // A stall fires on the cycle the counter would reach STALL_MAX without any state change.
  always_comb begin
    stall_err       = (state != HUNT) && (base_next == state) &&
                      (int'(stall_cnt) == STALL_MAX - 1);
    state_next      = stall_err ? HUNT : base_next;
    stall_cnt_next  = (state_next == HUNT || base_next != state) ? '0 : stall_cnt + SW'(1);
    stall_flag_next = stall_err | (err_stall & ~clr);
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      stall_cnt <= '0;
      err_stall <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      err_stall <= stall_flag_next;
    end
  end
`else
  assign state_next = base_next;
  assign err_stall  = 1'b0;
`endif

  // An increment coinciding with clr lands as 1; entering HUNT drops lock in the same cycle.
  always_comb begin
    count_next = clr ? 8'd0 : cycle_count;
    if (set_p2) count_next = clr ? 8'd1 : cycle_count + 8'd1;
    lock_next = lock_cnt;
    if (state_next == HUNT)
      lock_next = '0;
    else if (set_p2 && lock_cnt != LW'(LOCK_CYCLES))
      lock_next = lock_cnt + LW'(1);
    locked_next  = (lock_next == LW'(LOCK_CYCLES));
    overlap_next = overlap | (err_overlap & ~clr);
    order_next   = order_err | (err_order & ~clr);
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      phi1_q      <= 1'b0;
      phi2_q      <= 1'b0;
      p1_rise     <= 1'b0;
      p2_rise     <= 1'b0;
      cycle_count <= 8'd0;
      lock_cnt    <= '0;
      locked      <= 1'b0;
      err_overlap <= 1'b0;
      err_order   <= 1'b0;
    end else begin
      phi1_q      <= phi1;
      phi2_q      <= phi2;
      p1_rise     <= set_p1;
      p2_rise     <= set_p2;
      cycle_count <= count_next;
      lock_cnt    <= lock_next;
      locked      <= locked_next;
      err_overlap <= overlap_next;
      err_order   <= order_next;
    end
  end

endmodule

// File: tb/tb_tia_biphase_decoder.sv
// Directed self-checking bench for tia_biphase_decoder; expectations follow the watchdog macro setting.
`timescale 1ns/1ps
module tb_tia_biphase_decoder;

  logic       clk = 1'b0;
  logic       rn = 1'b0;
  logic       phi1 = 1'b0;
  logic       phi2 = 1'b0;
  logic       clr = 1'b0;
  logic       p1_rise, p2_rise, locked, err_overlap, err_order, err_stall;
  logic [7:0] cycle_count;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef TIA_BIPHASE_DECODER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  tia_biphase_decoder #(.STALL_MAX(8), .LOCK_CYCLES(2)) dut (
    .clk(clk), .rn(rn), .phi1(phi1), .phi2(phi2), .clr(clr),
    .p1_rise(p1_rise), .p2_rise(p2_rise), .cycle_count(cycle_count),
    .locked(locked), .err_overlap(err_overlap), .err_order(err_order),
    .err_stall(err_stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one sample on the falling edge, then return just after the rising edge that takes it.
  task automatic applyStimulus(input logic a, input logic b, input logic c);
    @(negedge clk);
    phi1 = a;
    phi2 = b;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cleanCycle(input logic [7:0] exp_count, input logic exp_lock, input logic chk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    if (chk) checkOutput("cyc_p1_rise", p1_rise, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    if (chk) checkOutput("cyc_p1_drop", p1_rise, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    if (chk) begin
      checkOutput("cyc_p2_rise", p2_rise, 1);
      checkOutput("cyc_count", cycle_count, exp_count);
      checkOutput("cyc_locked", locked, exp_lock);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    if (chk) checkOutput("cyc_p2_drop", p2_rise, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_p1", p1_rise, 0);
    checkOutput("rst_p2", p2_rise, 0);
    checkOutput("rst_count", cycle_count, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_flags", {err_overlap, err_order, err_stall}, 0);
    @(negedge clk);
    rn = 1'b1;

    // Four clean cycles; lock from the second p2 rise
    cleanCycle(8'd1, 1'b0, 1'b1);
    cleanCycle(8'd2, 1'b1, 1'b1);
    cleanCycle(8'd3, 1'b1, 1'b1);
    cleanCycle(8'd4, 1'b1, 1'b1);
    checkOutput("clean_flags", {err_overlap, err_order, err_stall}, 0);

    // Overlap while locked
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ovl_flag", err_overlap, 1);
    checkOutput("ovl_locked", locked, 0);
    checkOutput("ovl_no_strobe", p1_rise, 0);
    checkOutput("ovl_count", cycle_count, 4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    cleanCycle(8'd5, 1'b0, 1'b1);
    cleanCycle(8'd6, 1'b1, 1'b1);
    checkOutput("ovl_sticky", err_overlap, 1);

    // clr alone clears count and flags
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr_count", cycle_count, 0);
    checkOutput("clr_overlap", err_overlap, 0);

    // Order error: phi1 pulse, gap, phi1 pulse
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ord_first_p1", p1_rise, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ord_flag", err_order, 1);
    checkOutput("ord_locked", locked, 0);
    checkOutput("ord_no_strobe", p1_rise, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("ord_clr", err_order, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ord_hunt_p1", p1_rise, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("ord_clr_wins", err_order, 1);
    checkOutput("ord_clr_count", cycle_count, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Increment coinciding with clr leaves count at 1
    cleanCycle(8'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("clr_inc_count", cycle_count, 1);
    checkOutput("clr_inc_strobe", p2_rise, 1);
    checkOutput("clr_inc_locked", locked, 1);
    checkOutput("clr_inc_order", err_order, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // phi1 held high for ten samples
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stall_flag", err_stall, WD ? 8'd1 : 8'd0);
    checkOutput("stall_locked", locked, WD ? 8'd0 : 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stall_p2", p2_rise, WD ? 8'd0 : 8'd1);
    checkOutput("stall_count", cycle_count, WD ? 8'd1 : 8'd2);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Counter wrap
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("wrap_clr", cycle_count, 0);
    for (int i = 0; i < 255; i++) cleanCycle(8'd0, 1'b0, 1'b0);
    checkOutput("wrap_255", cycle_count, 255);
    cleanCycle(8'd0, 1'b1, 1'b1);
    cleanCycle(8'd1, 1'b1, 1'b1);

    // Reset in the middle of P2 while locked
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("mid_p2_locked", locked, 1);
    #2;
    rn = 1'b0;
    #1;
    checkOutput("mid_rst_p2", p2_rise, 0);
    checkOutput("mid_rst_count", cycle_count, 0);
    checkOutput("mid_rst_locked", locked, 0);
    @(negedge clk);
    phi2 = 1'b0;
    rn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_p2_ignored", p2_rise, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_p1", p1_rise, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_p2", p2_rise, 1);
    checkOutput("post_rst_count", cycle_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
